// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - 4-phase req/ack CDC transmitter with synchronized ack
// Optional REQ-phase timeout with sticky err is enabled by defining CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [STAGES-1:0] ack_ff;
  logic              ack_sync;
  logic              accept;
  logic              load;
  logic              abort;
  logic              req_nx;
  logic              done_nx;

  if (STAGES < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("cdc_handshake_tx: STAGES must be >= 2 and TIMEOUT >= 1");
  end

  // ack is asynchronous; only the last flop of this chain is ever observed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_ff <= '0;
    end else begin
      ack_ff <= {ack_ff[STAGES-2:0], ack};
    end
  end

  assign ack_sync  = ack_ff[STAGES-1];
  assign src_ready = rst && (state == IDLE) && !ack_sync;
  assign accept    = src_valid && src_ready;

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign abort = (state == REQ) && !ack_sync && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (load) begin
        cnt <= '0;
      end else if (state == REQ && !ack_sync) begin
        cnt <= cnt + 1'b1;
      end
      if (abort) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    req_nx   = req;
    done_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = REQ;
          req_nx   = 1'b1;
          load     = 1'b1;
        end
      end
      REQ: begin
        if (ack_sync || abort) begin
          state_nx = RELEASE;
          req_nx   = 1'b0;
        end
      end
      RELEASE: begin
        // an aborted handshake still waits for ack_sync low so the peer sees a full cycle
        if (!ack_sync) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_nx;
      req   <= req_nx;
      done  <= done_nx;
      if (load) begin
        data_out <= src_data;
      end
    end
  end

endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter: WIDTH, 8, payload width in bits.
REQ-002 Parameter: STAGES, 3, flop count of the internal ack synchronizer (min 2).
REQ-003 Parameter: TIMEOUT, 255, max cycles in REQ before abort (used only with CDC_TX_TIMEOUT_EN).
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: src_valid  input  1  source offers src_data.
REQ-007 Port: src_data  input  WIDTH  payload from source.
REQ-008 Port: src_ready  output  1  block can accept a payload this cycle.
REQ-009 Port: req  output  1  4-phase request to destination domain, registered, glitch-free.
REQ-010 Port: data_out  output  WIDTH  captured payload, registered, stable while req=1 and until ack_sync falls.
REQ-011 Port: ack  input  1  asynchronous acknowledge from destination domain.
REQ-012 Port: done  output  1  one-cycle pulse on handshake completion.
REQ-013 Port: err  output  1  sticky timeout flag.

Function
REQ-014 ack SHALL pass through STAGES flops clocked by clk; ack_sync = last flop; no other logic reads ack.
REQ-015 FSM states SHALL be IDLE, REQ, RELEASE.
REQ-016 src_ready SHALL be 1 only in IDLE with ack_sync=0.
REQ-017 Accept = src_valid & src_ready: data_out <= src_data, req <= 1, state -> REQ on the same edge; req high the cycle after accept.
REQ-018 REQ: ack_sync=1 -> req <= 0, state -> RELEASE; else hold.
REQ-019 RELEASE: ack_sync=0 -> state -> IDLE, done <= 1 for one cycle; else hold.
REQ-020 data_out SHALL change only on accept.
REQ-021 src_valid while src_ready=0 SHALL be ignored; no buffering.
REQ-022 Stale ack (ack_sync=1 in IDLE) SHALL block accept until ack_sync=0.
REQ-023 Back-to-back: accept allowed in the cycle done=1; req rises again the next cycle.
REQ-024 Minimum handshake, ack returned instantly: req high STAGES+1 cycles, low STAGES+1 cycles before next accept.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE, req=0, done=0, err=0, data_out=0, all sync flops=0, timeout counter=0.
REQ-026 Reset mid-handshake SHALL drop req without waiting for ack; after release, REQ-022 governs.
REQ-027 rst deassertion is synchronized externally; no internal reset synchronizer.

Configuration
REQ-028 Macro CDC_TX_TIMEOUT_EN defined: counter counts cycles in REQ, cleared on entering REQ; at TIMEOUT cycles without ack_sync -> req <= 0, state -> RELEASE, err <= 1 (sticky until reset); done SHALL still pulse on exit from RELEASE.
REQ-029 Macro undefined: no counter, REQ waits indefinitely, err tied to 0, TIMEOUT unused.

Verification (WIDTH=8, STAGES=3, TIMEOUT=20)
REQ-030 Reset: rst=0 with ack=1 -> req=0, src_ready=0 (ack_sync rises after 3 edges post-release), data_out=0, err=0.
REQ-031 Single transfer: src_data=0xA5 accepted at cycle 0; req=1 from cycle 1; ack=1 at cycle 3 -> req=0 at cycle 6; ack=0 at cycle 8 -> done=1 at cycle 11, src_ready=1 at cycle 11; data_out=0xA5 throughout.
REQ-032 Back-to-back: src_valid held with 0x11 then 0x22, responder echoes req as ack with 2-cycle delay -> two done pulses, data_out 0x11 then 0x22, second req rise exactly one cycle after first done.
REQ-033 Stale ack: ack held 1 after reset, src_valid=1 -> no accept, req=0 until ack=0 plus 3 cycles.
REQ-034 Reset mid-REQ: rst=0 two cycles after req rise -> req=0 asynchronously, state IDLE, no done pulse.
REQ-035 Timeout (macro defined): ack never asserted -> req falls 20 cycles after entering REQ, err=1 and stays 1, done pulses once; macro undefined -> req stays 1 for 100 cycles, err=0.
